// File: rtl/mac_array_ws.sv
// Weight-stationary systolic MAC array: row x col PEs, activations/instructions flow east,
// partial sums flow south. Supports kernel load, execute, flush and optional saturation.

module mac_array_ws_pe #(
    parameter int bw         = 4,
    parameter int psum_bw    = 16,
    parameter int SIGNED_ACT = 0,
    parameter int SAT        = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [bw-1:0]      act_in,
    input  logic [1:0]         inst_in,
    input  logic [psum_bw-1:0] psum_in,
    output logic [bw-1:0]      act_out,
    output logic [1:0]         inst_out,
    output logic [psum_bw-1:0] psum_out,
    output logic               exe_out
);
    localparam logic [1:0] INST_IDLE  = 2'b00;
    localparam logic [1:0] INST_LOAD  = 2'b01;
    localparam logic [1:0] INST_EXE   = 2'b10;
    localparam logic [1:0] INST_FLUSH = 2'b11;

    // Product held with headroom; sum one bit wider than the widest operand so
    // overflow is visible to the clamp.
    localparam int PW = 2 * bw + 2;
    localparam int EW = ((psum_bw > PW) ? psum_bw : PW) + 1;
    localparam bit SGN    = (SIGNED_ACT != 0);
    localparam bit DO_SAT = (SAT != 0);
    localparam logic signed [EW-1:0] PMAX = {{(EW-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
    localparam logic signed [EW-1:0] PMIN = {{(EW-psum_bw+1){1'b1}}, {(psum_bw-1){1'b0}}};

    logic [bw-1:0]         weight;
    logic                  load_ready;
    logic signed [PW-1:0]  act_x, wgt_x, prod;
    logic signed [EW-1:0]  sum;
    logic [psum_bw-1:0]    psum_next;

    always_comb begin
        act_x = {{(PW-bw){SGN & act_in[bw-1]}}, act_in};
        wgt_x = {{(PW-bw){weight[bw-1]}}, weight};
        prod  = act_x * wgt_x;
        sum   = {{(EW-psum_bw){psum_in[psum_bw-1]}}, psum_in}
              + {{(EW-PW){prod[PW-1]}}, prod};
        if (DO_SAT && (sum > PMAX))
            psum_next = PMAX[psum_bw-1:0];
        else if (DO_SAT && (sum < PMIN))
            psum_next = PMIN[psum_bw-1:0];
        else
            psum_next = sum[psum_bw-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            weight     <= '0;
            load_ready <= 1'b1;
            act_out    <= '0;
            inst_out   <= INST_IDLE;
            psum_out   <= '0;
            exe_out    <= 1'b0;
        end else begin
            act_out  <= act_in;
            inst_out <= inst_in;
            exe_out  <= (inst_in == INST_EXE);
            case (inst_in)
                INST_LOAD: begin
                    // The first load beat to reach an empty PE is consumed here.
                    if (load_ready) begin
                        weight     <= act_in;
                        load_ready <= 1'b0;
                        inst_out   <= INST_IDLE;
                    end
                end
                INST_EXE:   psum_out <= psum_next;
                INST_FLUSH: begin
                    weight     <= '0;
                    load_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

module mac_array_ws #(
    parameter int bw         = 4,
    parameter int psum_bw    = 16,
    parameter int row        = 8,
    parameter int col        = 8,
    parameter int SIGNED_ACT = 0,
    parameter int SAT        = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [psum_bw*col-1:0] out_s,
    input  logic [row*bw-1:0]      in_w,
    input  logic [psum_bw*col-1:0] in_n,
    input  logic [1:0]             inst_w,
    output logic [col-1:0]         valid
);
    logic [1:0]         skew_q [row];
    logic [bw-1:0]      act_h  [row][col];
    logic [1:0]         inst_h [row][col];
    logic [psum_bw-1:0] psum_v [row][col];
    logic [col-1:0]     exe_v  [row];
    logic [row-1:0]     unused_east;
    logic               unused_bits;

    // Row r sees the instruction r cycles late, matching the host's data skew.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < row; r++) skew_q[r] <= '0;
        end else begin
            skew_q[0] <= inst_w;
            for (int r = 1; r < row; r++) skew_q[r] <= skew_q[r-1];
        end
    end

    for (genvar r = 0; r < row; r++) begin : g_row
        for (genvar c = 0; c < col; c++) begin : g_col
            logic [bw-1:0]      a_in;
            logic [1:0]         i_in;
            logic [psum_bw-1:0] p_in;

            if (c == 0) begin : g_west
                assign a_in = in_w[bw*r +: bw];
                if (r == 0) begin : g_r0
                    assign i_in = inst_w;
                end else begin : g_rn
                    assign i_in = skew_q[r-1];
                end
            end else begin : g_inner
                assign a_in = act_h[r][c-1];
                assign i_in = inst_h[r][c-1];
            end

            if (r == 0) begin : g_north
                assign p_in = in_n[psum_bw*c +: psum_bw];
            end else begin : g_south
                assign p_in = psum_v[r-1][c];
            end

            mac_array_ws_pe #(
                .bw(bw), .psum_bw(psum_bw), .SIGNED_ACT(SIGNED_ACT), .SAT(SAT)
            ) u_pe (
                .clk      (clk),
                .reset    (reset),
                .act_in   (a_in),
                .inst_in  (i_in),
                .psum_in  (p_in),
                .act_out  (act_h[r][c]),
                .inst_out (inst_h[r][c]),
                .psum_out (psum_v[r][c]),
                .exe_out  (exe_v[r][c])
            );
        end
        assign unused_east[r] = ^{act_h[r][col-1], inst_h[r][col-1], exe_v[r]};
    end

    for (genvar c = 0; c < col; c++) begin : g_out
        assign out_s[psum_bw*c +: psum_bw] = psum_v[row-1][c];
        assign valid[c]                    = exe_v[row-1][c];
    end

    // East-edge outputs and upper-row execute bits have no consumer.
    assign unused_bits = ^{unused_east, skew_q[row-1]};
endmodule
